// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and default parameters for the register file with pending scoreboard.
// Optional write-to-read bypass is enabled by defining REGFILE_SCOREBOARD_WRITE_BYPASS_EN.
package regfile_scoreboard_pkg;

  // Defaults used by the CPU top when instantiating the block unparametrised.
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_NUM_REGS       = 16;
  localparam int DEF_NUM_READ_PORTS = 3;
  localparam int DEF_SEL_WIDTH      = $clog2(DEF_NUM_REGS);

  // Clear sequencer states.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Inputs of a default-parameter instance, bundled for the CPU top.
  typedef struct packed {
    logic [DEF_NUM_READ_PORTS*DEF_SEL_WIDTH-1:0] read_sel;
    logic                                        write_en;
    logic [DEF_SEL_WIDTH-1:0]                    write_sel;
    logic [DEF_DATA_WIDTH-1:0]                   write_data;
    logic                                        reserve_en;
    logic [DEF_SEL_WIDTH-1:0]                    reserve_sel;
    logic                                        flush;
  } port_in_s;

  // Outputs of a default-parameter instance.
  typedef struct packed {
    logic                                         ready;
    logic [DEF_NUM_READ_PORTS*DEF_DATA_WIDTH-1:0] read_data;
    logic [DEF_NUM_READ_PORTS-1:0]                read_pending;
  } port_out_s;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file scoreboard.
// The slave modport is the register file; the master modport is the pipeline side.
// Bypass behaviour selected elsewhere by REGFILE_SCOREBOARD_WRITE_BYPASS_EN.
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH     = regfile_scoreboard_pkg::DEF_DATA_WIDTH,
  parameter int NUM_REGS       = regfile_scoreboard_pkg::DEF_NUM_REGS,
  parameter int NUM_READ_PORTS = regfile_scoreboard_pkg::DEF_NUM_READ_PORTS
) ();

  localparam int SEL_WIDTH = $clog2(NUM_REGS);

  logic                                 ready;
  logic [NUM_READ_PORTS*SEL_WIDTH-1:0]  read_sel;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data;
  logic [NUM_READ_PORTS-1:0]            read_pending;
  logic                                 write_en;
  logic [SEL_WIDTH-1:0]                 write_sel;
  logic [DATA_WIDTH-1:0]                write_data;
  logic                                 reserve_en;
  logic [SEL_WIDTH-1:0]                 reserve_sel;
  logic                                 flush;

  modport slave (
    input  read_sel, write_en, write_sel, write_data, reserve_en, reserve_sel, flush,
    output ready, read_data, read_pending
  );

  modport master (
    output read_sel, write_en, write_sel, write_data, reserve_en, reserve_sel, flush,
    input  ready, read_data, read_pending
  );

endinterface

// File: rtl/regfile_scoreboard_read_port.sv
// One synchronous read port: register 0 reads as zero, nothing is returned until
// the clear sweep is done, and with REGFILE_SCOREBOARD_WRITE_BYPASS_EN defined a
// same-cycle write to the selected register is forwarded.
module regfile_scoreboard_read_port #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ready,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_pending,
  input  logic                  i_wr_en,
  input  logic [SEL_WIDTH-1:0]  i_wr_sel,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_pend_next,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_pending
);

  logic [DATA_WIDTH-1:0] w_data_d;
  logic                  w_pend_d;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_pending;

  // Select what this port captures at the next edge.
  always_comb begin
    w_data_d = '0;
    w_pend_d = 1'b0;
    if (i_ready && (i_sel != '0)) begin
      w_data_d = i_mem_data;
      w_pend_d = i_mem_pending;
`ifdef REGFILE_SCOREBOARD_WRITE_BYPASS_EN
      // i_sel is nonzero here, so a match also means the write itself is live.
      if (i_wr_en && (i_wr_sel == i_sel)) begin
        w_data_d = i_wr_data;
        w_pend_d = i_pend_next;
      end
`endif
    end
  end

`ifndef REGFILE_SCOREBOARD_WRITE_BYPASS_EN
  // Forwarding inputs are only consumed when the bypass is built in.
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_wr_en, i_wr_sel, i_wr_data, i_pend_next};
`endif

  // Registered read outputs, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_pending <= 1'b0;
    end else begin
      r_data    <= w_data_d;
      r_pending <= w_pend_d;
    end
  end

  assign o_data    = r_data;
  assign o_pending = r_pending;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register pending scoreboard and a post-reset
// clear sweep. Register 0 is hardwired zero. Decode reads and reserves destinations,
// writeback writes them and clears their pending bit; flush clears every pending bit.
// Define REGFILE_SCOREBOARD_WRITE_BYPASS_EN to forward same-cycle writes to readers.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_REGS       = DEF_NUM_REGS,
  parameter int NUM_READ_PORTS = DEF_NUM_READ_PORTS
) (
  input logic                clk,
  input logic                rst_n,
  regfile_scoreboard_if.slave rf
);

  localparam int SEL_WIDTH = $clog2(NUM_REGS);

  localparam logic [0:0] S_CLEAR = 1'(ST_CLEAR);
  localparam logic [0:0] S_READY = 1'(ST_READY);

  localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(NUM_REGS - 1);
  localparam logic [SEL_WIDTH-1:0] FIRST_IDX = SEL_WIDTH'(1);

  logic [0:0]            r_state;
  logic [SEL_WIDTH-1:0]  r_clear_idx;
  logic                  w_ready;

  logic [NUM_REGS-1:0]   r_pending;
  logic [NUM_REGS-1:0]   w_pending_next;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic                  w_mem_we;
  logic [SEL_WIDTH-1:0]  w_mem_sel;
  logic [DATA_WIDTH-1:0] w_mem_data;

  logic [DATA_WIDTH-1:0] w_port_data    [NUM_READ_PORTS];
  logic                  w_port_pending [NUM_READ_PORTS];

  assign w_ready  = (r_state == S_READY);
  assign rf.ready = w_ready;

  // Clear sequencer: sweep entries 1..NUM_REGS-1 once after reset, then stay ready.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CLEAR;
      r_clear_idx <= FIRST_IDX;
    end else if (r_state == S_CLEAR) begin
      if (r_clear_idx == LAST_IDX) begin
        r_state <= S_READY;
      end else begin
        r_clear_idx <= r_clear_idx + FIRST_IDX;
      end
    end
  end

  // Next pending vector: write clears, flush clears all, reserve sets (and wins
  // over a same-cycle write, being the newer producer). Bit 0 never gets set.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_pending_next = r_pending;
    if (w_ready) begin
      if (rf.write_en && (rf.write_sel != '0)) begin
        w_pending_next[rf.write_sel] = 1'b0;
      end
      if (rf.flush) begin
        w_pending_next = '0;
      end else if (rf.reserve_en && (rf.reserve_sel != '0)) begin
        w_pending_next[rf.reserve_sel] = 1'b1;
      end
    end
  end

  // Pending scoreboard, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // Array write port: the clear sweep owns it until ready, then writeback does.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_sel  = rf.write_sel;
    w_mem_data = rf.write_data;
    if (r_state == S_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_sel  = r_clear_idx;
      w_mem_data = '0;
    end else if (rf.write_en && (rf.write_sel != '0)) begin
      w_mem_we = 1'b1;
    end
  end

  // Register array storage; entry 0 is never written and is masked on read.
  // NOTE: the array has no reset so it maps onto plain storage; the clear
  // sweep gives it defined contents instead.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_sel] <= w_mem_data;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    logic [SEL_WIDTH-1:0] w_sel;
    assign w_sel = rf.read_sel[p*SEL_WIDTH +: SEL_WIDTH];

    regfile_scoreboard_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_WIDTH  (SEL_WIDTH)
    ) u_read_port (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_ready       (w_ready),
      .i_sel         (w_sel),
      .i_mem_data    (r_mem[w_sel]),
      .i_mem_pending (r_pending[w_sel]),
      .i_wr_en       (rf.write_en),
      .i_wr_sel      (rf.write_sel),
      .i_wr_data     (rf.write_data),
      .i_pend_next   (w_pending_next[w_sel]),
      .o_data        (w_port_data[p]),
      .o_pending     (w_port_pending[p])
    );
  end

  // Pack per-port results onto the flattened bus outputs.
  always_comb begin
    rf.read_data    = '0;
    rf.read_pending = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      rf.read_data[p*DATA_WIDTH +: DATA_WIDTH] = w_port_data[p];
      rf.read_pending[p]                       = w_port_pending[p];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
// Expectations for same-cycle read/write follow REGFILE_SCOREBOARD_WRITE_BYPASS_EN.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int NP = 3;
  localparam int SW = 4;

`ifdef REGFILE_SCOREBOARD_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ_PORTS(NP)) rf ();

  regfile_scoreboard #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ_PORTS(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sel3(input logic [SW-1:0] s0, input logic [SW-1:0] s1, input logic [SW-1:0] s2);
    rf.read_sel = {s2, s1, s0};
  endtask

  task automatic sel_all(input logic [SW-1:0] s);
    sel3(s, s, s);
  endtask

  function automatic logic [NP*DW-1:0] rep(input logic [DW-1:0] d);
    return {d, d, d};
  endfunction

  task automatic idle_inputs();
    rf.write_en    = 1'b0;
    rf.write_sel   = '0;
    rf.write_data  = '0;
    rf.reserve_en  = 1'b0;
    rf.reserve_sel = '0;
    rf.flush       = 1'b0;
  endtask

  task automatic wr(input logic [SW-1:0] s, input logic [DW-1:0] d);
    rf.write_en   = 1'b1;
    rf.write_sel  = s;
    rf.write_data = d;
  endtask

  task automatic rsv(input logic [SW-1:0] s);
    rf.reserve_en  = 1'b1;
    rf.reserve_sel = s;
  endtask

  // Count edges until ready rises, bounded; expect NUM_REGS-1.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (rf.ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check(tag, 128'(n), 128'(NR - 1));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    sel_all('0);
    step();
    step();
    check("rst_ready", 128'(rf.ready), 128'(0));
    check("rst_data", 128'(rf.read_data), 128'(0));
    check("rst_pend", 128'(rf.read_pending), 128'(0));

    // Release reset; write/reserve attempts during the sweep must be ignored.
    rst_n = 1'b1;
    wr(4'd3, 32'hFFFF_FFFF);
    rsv(4'd4);
    sel_all(4'd3);
    wait_ready("clear_len");
    check("clear_reads_zero", 128'(rf.read_data), 128'(0));
    idle_inputs();

    // Every register reads 0 with pending 0 after the sweep.
    for (int s = 1; s < NR; s++) begin
      sel_all(SW'(s));
      step();
      check($sformatf("init_r%0d_data", s), 128'(rf.read_data), 128'(0));
      check($sformatf("init_r%0d_pend", s), 128'(rf.read_pending), 128'(0));
    end

    // Write r3, then read on all ports with one-cycle latency.
    wr(4'd3, 32'hDEAD_BEEF);
    sel_all('0);
    step();
    idle_inputs();
    sel_all(4'd3);
    check("r3_latency", 128'(rf.read_data), 128'(0));
    step();
    check("r3_data", 128'(rf.read_data), 128'(rep(32'hDEAD_BEEF)));

    // Writes to r0 are dropped.
    wr(4'd0, 32'h1234);
    step();
    idle_inputs();
    sel_all('0);
    step();
    check("r0_data", 128'(rf.read_data), 128'(0));

    // Reserve r5, then write it.
    rsv(4'd5);
    step();
    idle_inputs();
    sel_all(4'd5);
    step();
    check("r5_rsv_pend", 128'(rf.read_pending), 128'(3'b111));
    check("r5_rsv_data", 128'(rf.read_data), 128'(0));
    sel_all('0);
    wr(4'd5, 32'h55);
    step();
    idle_inputs();
    sel_all(4'd5);
    step();
    check("r5_wr_pend", 128'(rf.read_pending), 128'(0));
    check("r5_wr_data", 128'(rf.read_data), 128'(rep(32'h55)));

    // Same-cycle write and reserve of r7: data written, pending 1. Ports independent.
    sel_all('0);
    wr(4'd7, 32'hA);
    rsv(4'd7);
    step();
    idle_inputs();
    sel3(4'd7, 4'd5, 4'd0);
    step();
    check("r7_mix_data", 128'(rf.read_data), 128'({32'h0, 32'h55, 32'hA}));
    check("r7_mix_pend", 128'(rf.read_pending), 128'(3'b001));

    // Reserve r2 and r4, then flush together with a reserve of r6.
    rsv(4'd2);
    step();
    rsv(4'd4);
    step();
    idle_inputs();
    sel3(4'd2, 4'd4, 4'd7);
    step();
    check("pre_flush_pend", 128'(rf.read_pending), 128'(3'b111));
    sel_all('0);
    rf.flush = 1'b1;
    rsv(4'd6);
    step();
    idle_inputs();
    sel3(4'd2, 4'd4, 4'd6);
    step();
    check("flush_pend", 128'(rf.read_pending), 128'(0));
    sel_all(4'd7);
    step();
    check("flush_r7_pend", 128'(rf.read_pending), 128'(0));
    check("flush_r7_data", 128'(rf.read_data), 128'(rep(32'hA)));

    // Flush with a write still updates data.
    rsv(4'd8);
    step();
    idle_inputs();
    rf.flush = 1'b1;
    wr(4'd8, 32'h88);
    step();
    idle_inputs();
    sel_all(4'd8);
    step();
    check("flush_wr_data", 128'(rf.read_data), 128'(rep(32'h88)));
    check("flush_wr_pend", 128'(rf.read_pending), 128'(0));

    // Same-cycle read/write of r9 (old value 0).
    sel_all(4'd9);
    wr(4'd9, 32'h99);
    step();
    idle_inputs();
    check("r9_same_data", 128'(rf.read_data), BYPASS ? 128'(rep(32'h99)) : 128'(0));
    check("r9_same_pend", 128'(rf.read_pending), 128'(0));
    step();
    check("r9_next_data", 128'(rf.read_data), 128'(rep(32'h99)));

    // Same-cycle read/write/reserve of r10: bypass shows post-update pending.
    sel_all(4'd10);
    wr(4'd10, 32'h10);
    rsv(4'd10);
    step();
    idle_inputs();
    check("r10_same_data", 128'(rf.read_data), BYPASS ? 128'(rep(32'h10)) : 128'(0));
    check("r10_same_pend", 128'(rf.read_pending), BYPASS ? 128'(3'b111) : 128'(0));
    step();
    check("r10_next_data", 128'(rf.read_data), 128'(rep(32'h10)));
    check("r10_next_pend", 128'(rf.read_pending), 128'(3'b111));

    // Asynchronous reset after writes: outputs drop without waiting for an edge.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 128'(rf.ready), 128'(0));
    check("arst_data", 128'(rf.read_data), 128'(0));
    check("arst_pend", 128'(rf.read_pending), 128'(0));
    step();
    rst_n = 1'b1;

    // Reset again six cycles into the sweep; the sweep must restart from 1.
    for (int i = 0; i < 6; i++) step();
    check("midclear_ready_low", 128'(rf.ready), 128'(0));
    #3;
    rst_n = 1'b0;
    #1;
    check("midclear_arst_ready", 128'(rf.ready), 128'(0));
    check("midclear_arst_data", 128'(rf.read_data), 128'(0));
    step();
    rst_n = 1'b1;
    wait_ready("restart_len");

    // Prior contents and pending bits are gone after the new sweep.
    sel3(4'd3, 4'd10, 4'd7);
    step();
    check("post_clear_data", 128'(rf.read_data), 128'(0));
    check("post_clear_pend", 128'(rf.read_pending), 128'(0));
    sel3(4'd5, 4'd8, 4'd9);
    step();
    check("post_clear_data2", 128'(rf.read_data), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
